handshake_const_check: RTL and testbench

Dataflow checker sitting at the consuming end of a constant-producing handshake channel. It accepts data tokens on a valid/ready input and compares each token against a compile-time constant. For each token it emits one dataless control token carrying a match flag, so that a datum becomes a control event again. A 2-entry elastic buffer decouples the two sides, and saturating mismatch statistics are kept for debug and self-check.

---
 rtl/handshake_pkg.sv | 10 +
 rtl/handshake_elastic_buf.sv | 80 ++++++++
 rtl/handshake_const_check.sv | 62 ++++++
 tb/tb_handshake_const_check.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/handshake_pkg.sv
// Shared definitions for the handshake checker slice.
package handshake_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } hs_buf_state_t;

endpackage

// File: rtl/handshake_elastic_buf.sv
// Two-entry elastic buffer with a registered input-ready.
module handshake_elastic_buf
  import handshake_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  hs_buf_state_t    state_q, state_d;
  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic             ready_q, ready_d;
  logic             accept;
  logic             deliver;

  // Next-state, slot updates and the registered-ready lookahead.
  always_comb begin
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    accept  = in_valid && ready_q;
    deliver = (state_q != EMPTY) && out_ready;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          slot0_d = in_data;
        end
      end
      ONE: begin
        case ({accept, deliver})
          2'b10: begin
            state_d = FULL;
            slot1_d = in_data;
          end
          2'b01: state_d = EMPTY;
          2'b11: slot0_d = in_data;
          default: ;
        endcase
      end
      FULL: begin
        if (deliver) begin
          state_d = ONE;
          slot0_d = slot1_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Ready is derived from the next state so it never depends on out_ready combinationally.
    ready_d = (state_d != FULL);
  end

  // State register; reset discards buffered entries immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      slot0_q <= '0;
      slot1_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      ready_q <= ready_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = slot0_q;

endmodule

// File: rtl/handshake_const_check.sv
// Compares incoming data tokens to a constant and emits match-flag control tokens.
module handshake_const_check
  import handshake_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] CONST_VALUE = DATA_WIDTH'(21'b010011011110000000111),
  parameter int unsigned          CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic                  outs_match,
  output logic [CNT_WIDTH-1:0]  mismatch_count,
  output logic                  mismatch_seen
);

  logic                 tok_match;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 seen_q, seen_d;

  assign tok_match = (ins == CONST_VALUE);

  handshake_elastic_buf #(.WIDTH(1)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_data   (tok_match),
    .in_valid  (ins_valid),
    .in_ready  (ins_ready),
    .out_valid (outs_valid),
    .out_data  (outs_match),
    .out_ready (outs_ready)
  );

  // Saturating mismatch statistics, updated on delivery of a mismatch token.
  always_comb begin
    count_d = count_q;
    seen_d  = seen_q;
    if (outs_valid && outs_ready && !outs_match) begin
      seen_d = 1'b1;
      if (count_q != '1) count_d = count_q + CNT_WIDTH'(1);
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      seen_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      seen_q  <= seen_d;
    end
  end

  assign mismatch_count = count_q;
  assign mismatch_seen  = seen_q;

endmodule

// File: tb/tb_handshake_const_check.sv
// Directed and scoreboarded bench for handshake_const_check.
module tb_handshake_const_check;

  localparam logic [31:0] C = 32'h0009_BC07;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ins = '0;
  logic        ins_valid = 1'b0;
  logic        ins_ready;
  logic        outs_valid;
  logic        outs_ready = 1'b0;
  logic        outs_match;
  logic [15:0] mismatch_count;
  logic        mismatch_seen;

  logic [31:0] s_ins = '0;
  logic        s_ins_valid = 1'b0;
  logic        s_ins_ready;
  logic        s_outs_valid;
  logic        s_outs_ready = 1'b0;
  logic        s_outs_match;
  logic [3:0]  s_count;
  logic        s_seen;

  int n_checks = 0;
  int n_fail   = 0;

  // model
  bit       m_q[$];
  bit       m_ready;
  int       m_mc;
  bit       m_seen;
  logic [31:0] dlv_log;
  int       n_dlv;

  always #5 clk = ~clk;

  handshake_const_check dut (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .outs_valid(outs_valid), .outs_ready(outs_ready), .outs_match(outs_match),
    .mismatch_count(mismatch_count), .mismatch_seen(mismatch_seen)
  );

  handshake_const_check #(.CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .ins(s_ins), .ins_valid(s_ins_valid), .ins_ready(s_ins_ready),
    .outs_valid(s_outs_valid), .outs_ready(s_outs_ready), .outs_match(s_outs_match),
    .mismatch_count(s_count), .mismatch_seen(s_seen)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_ready = 1'b0;
    m_mc    = 0;
    m_seen  = 1'b0;
  endtask

  // Called at posedge+1: check outputs against the model, drive inputs, advance one edge.
  task automatic cycle(input logic v, input logic [31:0] d, input logic r, output bit accepted);
    bit acc, dlv, b;
    ins_valid  = v;
    ins        = d;
    outs_ready = r;
    check("ins_ready", ins_ready, m_ready);
    check("outs_valid", outs_valid, m_q.size() != 0);
    if (m_q.size() != 0) check("outs_match", outs_match, m_q[0]);
    check("mismatch_count", mismatch_count, m_mc);
    check("mismatch_seen", mismatch_seen, m_seen);
    if (outs_valid && r) begin
      dlv_log = {dlv_log[30:0], outs_match};
      n_dlv++;
    end
    acc = v && m_ready;
    dlv = (m_q.size() != 0) && r;
    if (dlv) begin
      b = m_q.pop_front();
      if (!b) begin
        m_seen = 1'b1;
        if (m_mc != 16'hFFFF) m_mc++;
      end
    end
    if (acc) m_q.push_back(d == C);
    m_ready = (m_q.size() != 2);
    @(posedge clk);
    #1;
    accepted = acc;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ins_valid = 1'b0;
    outs_ready = 1'b0;
    model_clear();
    #1;
    check("rst_ins_ready", ins_ready, 0);
    check("rst_outs_valid", outs_valid, 0);
    check("rst_outs_match", outs_match, 0);
    check("rst_count", mismatch_count, 0);
    check("rst_seen", mismatch_seen, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    dlv_log = '0;
    n_dlv = 0;
  endtask

  initial begin
    bit a;
    int acc_cnt;
    int cyc;
    logic [31:0] d;

    @(posedge clk);
    #1;
    do_reset();

    // first edge after release raises ready
    cycle(1'b0, 32'hDEAD_BEEF, 1'b1, a);
    check("rdy_after_rst", ins_ready, 1);

    // single matching token
    cycle(1'b1, C, 1'b1, a);
    check("single_valid", outs_valid, 1);
    check("single_match", outs_match, 1);
    cycle(1'b0, '0, 1'b1, a);
    check("single_drained", outs_valid, 0);
    check("single_count", mismatch_count, 0);

    // streaming alternating pattern
    do_reset();
    cycle(1'b0, '0, 1'b1, a);
    for (int i = 0; i < 8; i++) cycle(1'b1, (i % 2 == 0) ? C : 32'h0, 1'b1, a);
    cycle(1'b0, '0, 1'b1, a);
    check("stream_n", n_dlv, 8);
    check("stream_order", dlv_log[7:0], 8'b1010_1010);
    check("stream_count", mismatch_count, 4);
    check("stream_seen", mismatch_seen, 1);

    // backpressure
    do_reset();
    cycle(1'b0, '0, 1'b0, a);
    cycle(1'b1, C, 1'b0, a);
    check("bp_acc0", a, 1);
    cycle(1'b1, 32'h0, 1'b0, a);
    check("bp_acc1", a, 1);
    check("bp_ready_low", ins_ready, 0);
    cycle(1'b1, C, 1'b0, a);
    check("bp_acc2_blocked", a, 0);
    check("bp_hold_match", outs_match, 1);
    cycle(1'b1, C, 1'b1, a);
    check("bp_release_acc", a, 0);
    check("bp_head_b", outs_match, 0);
    cycle(1'b1, C, 1'b1, a);
    check("bp_third_acc", a, 1);
    cycle(1'b0, '0, 1'b1, a);
    check("bp_n", n_dlv, 3);
    check("bp_order", dlv_log[2:0], 3'b101);
    check("bp_count", mismatch_count, 1);

    // random scoreboard run
    do_reset();
    acc_cnt = 0;
    cyc = 0;
    while (acc_cnt < 1000 && cyc < 10000) begin
      logic v;
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 1) != 0) ? C : $urandom();
      cycle(v, d, ($urandom_range(0, 2) != 0), a);
      if (a) acc_cnt++;
      cyc++;
    end
    check("rand_accepted", acc_cnt, 1000);
    for (int i = 0; i < 4; i++) cycle(1'b0, $urandom(), 1'b1, a);
    check("rand_delivered", n_dlv, 1000);
    check("rand_empty", outs_valid, 0);

    // async reset with two tokens buffered
    do_reset();
    cycle(1'b0, '0, 1'b1, a);
    cycle(1'b1, 32'h1, 1'b1, a);
    cycle(1'b0, '0, 1'b1, a);
    cycle(1'b1, C, 1'b0, a);
    cycle(1'b1, 32'h0, 1'b0, a);
    check("ar_full", outs_valid, 1);
    check("ar_count_pre", mismatch_count, 1);
    #2;
    rst = 1'b0;
    model_clear();
    #1;
    check("ar_valid", outs_valid, 0);
    check("ar_count", mismatch_count, 0);
    check("ar_seen", mismatch_seen, 0);
    check("ar_ready", ins_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    ins_valid = 1'b0;
    @(posedge clk);
    #1;
    check("ar_ready_after", ins_ready, 1);
    check("ar_valid_after", outs_valid, 0);

    // saturation on the 4-bit counter instance
    check("sat_start", s_count, 0);
    s_ins = 32'h0;
    s_ins_valid = 1'b1;
    s_outs_ready = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("sat_count", s_count, 4'hF);
    check("sat_seen", s_seen, 1);
    repeat (5) @(posedge clk);
    #1;
    check("sat_steady", s_count, 4'hF);
    check("sat_seen_steady", s_seen, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
